// File: rtl/axp_mem_pkg.sv
// Shared opcode, state and bus-payload definitions for the AXP load/store unit.
package axp_mem_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned BE_W = 8;
    localparam int unsigned OP_W = 6;

    localparam logic [OP_W-1:0] OP_LDBU  = 6'h0A;
    localparam logic [OP_W-1:0] OP_LDQ_U = 6'h0B;
    localparam logic [OP_W-1:0] OP_LDWU  = 6'h0C;
    localparam logic [OP_W-1:0] OP_STW   = 6'h0D;
    localparam logic [OP_W-1:0] OP_STB   = 6'h0E;
    localparam logic [OP_W-1:0] OP_STQ_U = 6'h0F;
    localparam logic [OP_W-1:0] OP_LDL   = 6'h28;
    localparam logic [OP_W-1:0] OP_LDQ   = 6'h29;
    localparam logic [OP_W-1:0] OP_LDL_L = 6'h2A;
    localparam logic [OP_W-1:0] OP_LDQ_L = 6'h2B;
    localparam logic [OP_W-1:0] OP_STL   = 6'h2C;
    localparam logic [OP_W-1:0] OP_STQ   = 6'h2D;
    localparam logic [OP_W-1:0] OP_STL_C = 6'h2E;
    localparam logic [OP_W-1:0] OP_STQ_C = 6'h2F;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

    // Captured bus request, held stable while mem_valid is up.
    typedef struct packed {
        logic            write;
        logic [XLEN-1:0] addr;
        logic [BE_W-1:0] be;
        logic [XLEN-1:0] wdata;
    } mem_req_t;

    function automatic logic is_store(input logic [OP_W-1:0] op);
        return op inside {OP_STB, OP_STW, OP_STQ_U, OP_STL, OP_STQ, OP_STL_C, OP_STQ_C};
    endfunction

    function automatic logic is_load(input logic [OP_W-1:0] op);
        return op inside {OP_LDBU, OP_LDWU, OP_LDQ_U, OP_LDL, OP_LDQ, OP_LDL_L, OP_LDQ_L};
    endfunction

    function automatic logic is_locked(input logic [OP_W-1:0] op);
        return op inside {OP_LDL_L, OP_LDQ_L};
    endfunction

    function automatic logic is_cond(input logic [OP_W-1:0] op);
        return op inside {OP_STL_C, OP_STQ_C};
    endfunction

    function automatic logic is_quad_u(input logic [OP_W-1:0] op);
        return op inside {OP_LDQ_U, OP_STQ_U};
    endfunction

    function automatic logic [3:0] popcount8(input logic [BE_W-1:0] m);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) n = n + 4'(m[i]);
        return n;
    endfunction

endpackage

// File: rtl/axp_lsu_align.sv
// Store-lane shift and load extract/extend for the AXP load/store unit.
module axp_lsu_align
    import axp_mem_pkg::*;
(
    input  logic [5:0]  op,
    input  logic [2:0]  off,
    input  logic [63:0] st_data,
    input  logic [63:0] ld_data,
    output logic [63:0] wdata_c,
    output logic [63:0] rdata_c
);

    logic [5:0]  sh;
    logic [31:0] v;

    // Shift store data into its byte lanes; pull load data down and extend.
    always_comb begin
        sh      = {off, 3'b000};
        wdata_c = st_data << sh;
        v       = 32'(ld_data >> sh);
        rdata_c = ld_data;
        case (op)
            OP_LDBU:          rdata_c = {56'd0, v[7:0]};
            OP_LDWU:          rdata_c = {48'd0, v[15:0]};
            OP_LDL, OP_LDL_L: rdata_c = {{32{v[31]}}, v};
            default:          rdata_c = ld_data;
        endcase
    end

endmodule

// File: rtl/axp_lsu.sv
// AXP load/store unit: one memory instruction per transaction, with LDx_L/STx_C lock.
module axp_lsu
    import axp_mem_pkg::*;
#(
    parameter int unsigned LOCK_SHIFT = 4,
    parameter bit          MEM_WAIT   = 1'b1
)
(
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_cmd,
    input  logic [63:0] req_addr,
    input  logic [7:0]  req_mask,
    input  logic [63:0] req_data,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic        mem_write,
    output logic [63:0] mem_addr,
    output logic [7:0]  mem_be,
    output logic [63:0] mem_wdata,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        lock_clear,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [63:0] rsp_data,
    output logic        rsp_fault
);

    localparam int unsigned LK_W = 64 - LOCK_SHIFT;

    state_t          state_q, state_n;
    mem_req_t        mreq_q;
    logic [5:0]      op_q;
    logic [2:0]      off_q;
    logic [LK_W-1:0] gran_q;
    logic            lock_valid;
    logic [LK_W-1:0] lock_addr;

    logic [5:0]  req_op_c, align_op_c;
    logic [2:0]  req_off_c, align_off_c;
    logic [3:0]  sz_m1_c;
    logic        fault_c, lock_hit_c, cond_fail_c, accept_c;
    logic        load_cap_c, lock_set_c, lock_drop_c;
    logic [63:0] wdata_c, rdata_c;
    logic        unused_c;

    assign unused_c = ^{req_cmd[25:0], sz_m1_c[3]};

    // Request decode, fault check, lock lookup and lock update conditions.
    always_comb begin
        req_op_c    = req_cmd[31:26];
        req_off_c   = is_quad_u(req_op_c) ? 3'd0 : req_addr[2:0];
        sz_m1_c     = popcount8(req_mask) - 4'd1;
        fault_c     = !is_legal_op(req_op_c) ||
                      (!is_quad_u(req_op_c) && ((req_addr[2:0] & sz_m1_c[2:0]) != 3'd0));
        lock_hit_c  = lock_valid && (lock_addr == req_addr[63:LOCK_SHIFT]);
        cond_fail_c = is_cond(req_op_c) && !lock_hit_c;
        accept_c    = (state_q == IDLE) && req_valid;
        align_op_c  = (state_q == IDLE) ? req_op_c : op_q;
        align_off_c = (state_q == IDLE) ? req_off_c : off_q;
        if (MEM_WAIT) load_cap_c = (state_q == WAIT) && mem_rvalid;
        else          load_cap_c = (state_q == REQ) && mem_ready && !mreq_q.write;
        lock_set_c  = load_cap_c && is_locked(op_q);
        lock_drop_c = (accept_c && !fault_c && is_cond(req_op_c)) ||
                      ((state_q == REQ) && mem_ready && mreq_q.write &&
                       !is_cond(op_q) && (gran_q == lock_addr));
    end

    function automatic logic is_legal_op(input logic [5:0] op);
        return is_load(op) || is_store(op);
    endfunction

    // Next-state logic.
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            IDLE: if (req_valid) state_n = (fault_c || cond_fail_c) ? RESP : REQ;
            REQ:  if (mem_ready) state_n = (mreq_q.write || !MEM_WAIT) ? RESP : WAIT;
            WAIT: if (mem_rvalid) state_n = RESP;
            RESP: if (rsp_ready) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // State register and registered handshake flags.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= IDLE;
            req_ready <= 1'b1;
            mem_valid <= 1'b0;
            rsp_valid <= 1'b0;
        end else begin
            state_q   <= state_n;
            req_ready <= (state_n == IDLE);
            mem_valid <= (state_n == REQ);
            rsp_valid <= (state_n == RESP);
        end
    end

    // Capture request fields at acceptance and load data at return.
    always_ff @(posedge clock) begin
        if (reset) begin
            mreq_q    <= '0;
            op_q      <= '0;
            off_q     <= '0;
            gran_q    <= '0;
            rsp_data  <= '0;
            rsp_fault <= 1'b0;
        end else begin
            if (accept_c) begin
                op_q         <= req_op_c;
                off_q        <= req_off_c;
                gran_q       <= req_addr[63:LOCK_SHIFT];
                mreq_q.write <= is_store(req_op_c);
                mreq_q.addr  <= {req_addr[63:3], 3'b000};
                mreq_q.be    <= req_mask << req_off_c;
                mreq_q.wdata <= wdata_c;
                rsp_fault    <= fault_c;
                rsp_data     <= (is_cond(req_op_c) && !fault_c && lock_hit_c) ? 64'd1 : 64'd0;
            end
            if (load_cap_c) rsp_data <= rdata_c;
        end
    end

    // Lock flag: snoop clear beats a same-cycle set.
    always_ff @(posedge clock) begin
        if (reset) begin
            lock_valid <= 1'b0;
            lock_addr  <= '0;
        end else if (lock_clear) begin
            lock_valid <= 1'b0;
        end else if (lock_set_c) begin
            lock_valid <= 1'b1;
            lock_addr  <= gran_q;
        end else if (lock_drop_c) begin
            lock_valid <= 1'b0;
        end
    end

    assign mem_write = mreq_q.write;
    assign mem_addr  = mreq_q.addr;
    assign mem_be    = mreq_q.be;
    assign mem_wdata = mreq_q.wdata;

    axp_lsu_align u_align (
        .op      (align_op_c),
        .off     (align_off_c),
        .st_data (req_data),
        .ld_data (mem_rdata),
        .wdata_c (wdata_c),
        .rdata_c (rdata_c)
    );

endmodule
